// File: rtl/animation_platform_pkg.sv
// Shared constants for the platform overlay: screen geometry, row placement and tile size.
// Also holds the pipeline record type and the ramp-offset helper used by the geometry block.
package animation_platform_pkg;

    localparam int TILE_W    = 64;
    localparam int TILE_H    = 32;
    localparam int H_ACTIVE  = 1024;
    localparam int V_ACTIVE  = 768;
    localparam int NUM_ROWS  = 6;
    localparam int MAX_LEVEL = 6;

    localparam logic [11:0] TRANSPARENT = 12'h000;

    localparam logic [10:0] ROW_Y     [0:5] = '{11'd96, 11'd224, 11'd352, 11'd480, 11'd608, 11'd736};
    localparam logic [10:0] ROW_X_MIN [0:5] = '{11'd0, 11'd0, 11'd64, 11'd0, 11'd64, 11'd0};
    localparam logic [10:0] ROW_X_MAX [0:5] = '{11'd1023, 11'd959, 11'd1023, 11'd959, 11'd1023, 11'd1023};

    typedef logic [2:0] level_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_sig_t;

    // Odd rows slope down to the right (2*c), even rows the other way (2*(15-c) == 2*~c).
    function automatic logic [4:0] rampOffset(input int k, input logic [3:0] tileCol);
        return (k % 2 == 1) ? {tileCol, 1'b0} : {~tileCol, 1'b0};
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between overlay stages.
interface vga_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport sink   (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport source (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/platform_geometry.sv
// Combinational row hit test: decides whether the current pixel lies on a revealed platform
// row and, if so, which tile ROM address to fetch.
module platform_geometry
    import animation_platform_pkg::*;
(
    input  logic [10:0] hcount_i,
    input  logic [10:0] vcount_i,
    input  level_t      level_i,
    input  logic [3:0]  ramp_en_i,
    output logic        hit_o,
    output logic [10:0] pixel_addr_o
);

    logic [3:0]  tileCol;
    logic        inActive;
    logic [5:0]  rampRows;
    logic [4:0]  rowOff;
    logic [10:0] vrel;
    logic        revealed;
    logic        inX;

    assign tileCol  = hcount_i[9:6];
    assign inActive = (hcount_i < 11'(H_ACTIVE)) && (vcount_i < 11'(V_ACTIVE));
    assign rampRows = {1'b0, ramp_en_i, 1'b0};

    // vrel is unsigned: a pixel above the row wraps to a large value and fails the < TILE_H test.
    always_comb begin
        hit_o        = 1'b0;
        pixel_addr_o = '0;
        rowOff       = '0;
        vrel         = '0;
        revealed     = 1'b0;
        inX          = 1'b0;
        for (int k = 0; k < NUM_ROWS; k++) begin
            rowOff   = rampRows[k] ? rampOffset(k, tileCol) : 5'd0;
            vrel     = vcount_i - ROW_Y[k] - 11'(rowOff);
            revealed = 3'(NUM_ROWS - 1 - k) < level_i;
            inX      = (hcount_i >= ROW_X_MIN[k]) && (hcount_i <= ROW_X_MAX[k]);
            if (inActive && inX && revealed && (vrel < 11'(TILE_H))) begin
                hit_o        = 1'b1;
                pixel_addr_o = {vrel[4:0], hcount_i[5:0]};
            end
        end
    end

endmodule

// File: rtl/animation_platform.sv
// Platform overlay stage: frame-paced bottom-up reveal of girder rows, tile ROM lookup and a
// two-stage pipeline that keeps the VGA timing aligned with the returning ROM data.
module animation_platform
    import animation_platform_pkg::*;
#(
    parameter int ROW_STEP_FRAMES = 16
)
(
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] pixel_addr,
    input  logic [11:0] rgb_pixel,
    input  logic        start_game,
    input  logic [3:0]  ramp_en,
    vga_if.sink         in,
    vga_if.source       out
);

    localparam int FRAME_MAX = MAX_LEVEL * ROW_STEP_FRAMES;
    localparam int CNT_W     = $clog2(FRAME_MAX + 1);

    logic [CNT_W-1:0] frames_q, frames_d;
    logic             vblnkPrev_q;
    logic [31:0]      frameSteps;
    level_t           level;
    logic             hit;

    vga_sig_t   inSig;
    vga_sig_t   stage_q;
    logic       stageHit_q;
    vga_sig_t   out_q, out_d;

    assign inSig = '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync, vsync: in.vsync,
                     hblnk: in.hblnk, vblnk: in.vblnk, rgb: in.rgb};

    // Level follows start_game live; the counter only paces rows once the game has started.
    always_comb begin
        frameSteps = 32'(frames_q) / ROW_STEP_FRAMES;
        if (!start_game) begin
            level = '0;
        end else if (frameSteps >= 32'(MAX_LEVEL - 1)) begin
            level = 3'(MAX_LEVEL);
        end else begin
            level = 3'(frameSteps + 32'd1);
        end

        frames_d = frames_q;
        if (!start_game) begin
            frames_d = '0;
        end else if (in.vblnk && !vblnkPrev_q && (frames_q != CNT_W'(FRAME_MAX))) begin
            frames_d = frames_q + 1'b1;
        end
    end

    platform_geometry u_geometry (
        .hcount_i     (in.hcount),
        .vcount_i     (in.vcount),
        .level_i      (level),
        .ramp_en_i    (ramp_en),
        .hit_o        (hit),
        .pixel_addr_o (pixel_addr)
    );

    // ROM data arrives while the first stage holds the matching pixel, so the mux sits there.
    always_comb begin
        out_d = stage_q;
        if (stageHit_q && (rgb_pixel != TRANSPARENT)) begin
            out_d.rgb = rgb_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q    <= '0;
            vblnkPrev_q <= 1'b0;
            stage_q     <= '0;
            stageHit_q  <= 1'b0;
            out_q       <= '0;
        end else begin
            frames_q    <= frames_d;
            vblnkPrev_q <= in.vblnk;
            stage_q     <= inSig;
            stageHit_q  <= hit;
            out_q       <= out_d;
        end
    end

    assign out.hcount = out_q.hcount;
    assign out.vcount = out_q.vcount;
    assign out.hsync  = out_q.hsync;
    assign out.vsync  = out_q.vsync;
    assign out.hblnk  = out_q.hblnk;
    assign out.vblnk  = out_q.vblnk;
    assign out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_animation_platform.sv
// Randomized bench for animation_platform: a behavioural row/reveal model predicts pixel_addr
// every cycle and the full out bundle two cycles later, with a few literal pins on top.
module tb_animation_platform;

    localparam int STEP       = 16;
    localparam int FRAME_MAX  = 6 * STEP;
    localparam int ACTIVE_CYC = 150;

    typedef struct {
        int          hc;
        int          vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        hit;
        logic [10:0] addr;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] pixel_addr;
    logic [11:0] rgb_pixel;
    logic        start_game;
    logic [3:0]  ramp_en;

    vga_if vin ();
    vga_if vout ();

    animation_platform #(.ROW_STEP_FRAMES(STEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_addr (pixel_addr),
        .rgb_pixel  (rgb_pixel),
        .start_game (start_game),
        .ramp_en    (ramp_en),
        .in         (vin),
        .out        (vout)
    );

    int   compared   = 0;
    int   mismatched = 0;
    int   modelFrames;
    logic modelPrevV;
    logic nextRst;
    logic nextStart;
    logic [3:0] nextRamp;
    logic outValid = 1'b0;
    rec_t zeroRec;
    rec_t curRec;
    rec_t stageRec;
    rec_t expOut;

    always #5 clk = ~clk;

    // Synchronous tile ROM stand-in; addresses ending in 3 hold transparent black.
    function automatic logic [11:0] romData(input logic [10:0] addr);
        if (addr[2:0] == 3'd3) return 12'h000;
        return {addr, 1'b1} ^ 12'h3C0;
    endfunction

    always @(posedge clk) rgb_pixel <= romData(pixel_addr);

    function automatic int modelLevel(input logic sg, input int frames);
        int lv;
        if (!sg) return 0;
        lv = 1 + frames / STEP;
        return (lv > 6) ? 6 : lv;
    endfunction

    // Row placement straight from the screen description: y = 96+128k, extents, ramp offsets.
    function automatic void modelGeom(input int hc, input int vc, input int lvl, input logic [3:0] ramp,
                                      output logic hit, output logic [10:0] addr);
        hit  = 1'b0;
        addr = '0;
        if (hc >= 1024 || vc >= 768) return;
        for (int k = 0; k < 6; k++) begin
            int y   = 96 + 128 * k;
            int c   = hc / 64;
            int off = 0;
            int xlo = (k == 2 || k == 4) ? 64 : 0;
            int xhi = (k == 1 || k == 3) ? 959 : 1023;
            int vr;
            if (k >= 1 && k <= 4 && ramp[k-1]) off = (k % 2 == 1) ? 2 * c : 2 * (15 - c);
            vr = vc - y - off;
            if (hc >= xlo && hc <= xhi && vr >= 0 && vr < 32 && (5 - k) < lvl) begin
                hit  = 1'b1;
                addr = 11'(vr * 64 + hc % 64);
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Advance the model across one rising edge using the inputs that were present before it.
    task automatic modelClock();
        if (rst) begin
            modelFrames = 0;
            modelPrevV  = 1'b0;
            stageRec    = zeroRec;
            expOut      = zeroRec;
        end else begin
            expOut = stageRec;
            if (stageRec.hit && romData(stageRec.addr) != 12'h000) expOut.rgb = romData(stageRec.addr);
            stageRec = curRec;
            if (!start_game) modelFrames = 0;
            else if (vin.vblnk && !modelPrevV && modelFrames < FRAME_MAX) modelFrames++;
            modelPrevV = vin.vblnk;
        end
        outValid = 1'b1;
    endtask

    task automatic applyStimulus(input int hc, input int vc, input logic hs, input logic vs,
                                 input logic hb, input logic vb, input logic [11:0] rgb);
        logic        h;
        logic [10:0] a;
        @(posedge clk);
        modelClock();
        #1;
        rst        = nextRst;
        start_game = nextStart;
        ramp_en    = nextRamp;
        vin.hcount = 11'(hc);
        vin.vcount = 11'(vc);
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
        modelGeom(hc, vc, modelLevel(nextStart, modelFrames), nextRamp, h, a);
        curRec = '{hc: hc, vc: vc, hs: hs, vs: vs, hb: hb, vb: vb, rgb: rgb, hit: h, addr: a};
    endtask

    task automatic randomActive();
        int k  = int'($urandom_range(0, 5));
        int hc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1024, 1343)) : int'($urandom_range(0, 1023));
        int vc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 767))
                                              : 96 + 128 * k + int'($urandom_range(0, 67)) - 2;
        if (vc > 767) vc = 767;
        applyStimulus(hc, vc, hc >= 1048 && hc < 1184, 1'b0, hc >= 1024, 1'b0, 12'($urandom));
    endtask

    task automatic runFrame();
        for (int i = 0; i < ACTIVE_CYC; i++) randomActive();
        for (int v = 768; v < 778; v++)
            applyStimulus(int'($urandom_range(0, 1343)), v, 1'b0, v >= 771 && v < 777, 1'b1, 1'b1, 12'($urandom));
    endtask

    always @(negedge clk) begin
        if (outValid) begin
            checkOutput("out.hcount", 32'(vout.hcount), 32'(expOut.hc));
            checkOutput("out.vcount", 32'(vout.vcount), 32'(expOut.vc));
            checkOutput("out.hsync",  32'(vout.hsync),  32'(expOut.hs));
            checkOutput("out.vsync",  32'(vout.vsync),  32'(expOut.vs));
            checkOutput("out.hblnk",  32'(vout.hblnk),  32'(expOut.hb));
            checkOutput("out.vblnk",  32'(vout.vblnk),  32'(expOut.vb));
            checkOutput("out.rgb",    32'(vout.rgb),    32'(expOut.rgb));
            checkOutput("pixel_addr", 32'(pixel_addr),  32'(curRec.addr));
        end
    end

    initial begin
        logic        h;
        logic [10:0] a;

        zeroRec  = '{hc: 0, vc: 0, hs: 0, vs: 0, hb: 0, vb: 0, rgb: 12'h000, hit: 0, addr: 11'd0};
        curRec   = zeroRec;
        stageRec = zeroRec;
        expOut   = zeroRec;
        modelFrames = 0;
        modelPrevV  = 1'b0;

        // Hand-computed anchors for the model itself.
        modelGeom(5, 740, 1, 4'b0000, h, a);    checkOutput("model floor hit", 32'(h), 1);
                                                checkOutput("model floor addr", 32'(a), 261);
        modelGeom(5, 620, 1, 4'b0000, h, a);    checkOutput("model row4 hidden", 32'(h), 0);
        modelGeom(100, 610, 2, 4'b0000, h, a);  checkOutput("model row4 addr", 32'(a), 164);
        modelGeom(10, 610, 2, 4'b0000, h, a);   checkOutput("model row4 left edge", 32'(h), 0);
        modelGeom(323, 236, 6, 4'b0001, h, a);  checkOutput("model ramp1 addr", 32'(a), 131);
        modelGeom(320, 266, 6, 4'b0001, h, a);  checkOutput("model ramp1 below", 32'(h), 0);
        modelGeom(980, 240, 6, 4'b0001, h, a);  checkOutput("model row1 right edge", 32'(h), 0);
        modelGeom(64, 411, 6, 4'b0010, h, a);   checkOutput("model ramp2 last line", 32'(a), 1984);
        modelGeom(64, 379, 6, 4'b0010, h, a);   checkOutput("model ramp2 above", 32'(h), 0);

        nextRst = 1'b1; nextStart = 1'b0; nextRamp = 4'b0000;
        rst = 1'b1; start_game = 1'b0; ramp_en = 4'b0000;
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

        repeat (4) randomActive();
        nextRst = 1'b0;
        runFrame();
        runFrame();

        nextStart = 1'b1;
        applyStimulus(5, 740, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC);
        #2 checkOutput("dut floor addr", 32'(pixel_addr), 261);
        applyStimulus(1100, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h111);
        applyStimulus(1100, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h222);
        #2 checkOutput("dut rom replaces rgb", 32'(vout.rgb), 32'h1CB);
        applyStimulus(100, 610, 1'b0, 1'b0, 1'b0, 1'b0, 12'h333);
        #2 checkOutput("dut row4 hidden", 32'(pixel_addr), 0);

        for (int f = 0; f < 100; f++) begin
            if (f >= 20) nextRamp = 4'($urandom);
            runFrame();
        end

        nextRamp = 4'b0001;
        applyStimulus(323, 236, 1'b0, 1'b0, 1'b0, 1'b0, 12'h444);
        #2 checkOutput("dut ramp1 addr", 32'(pixel_addr), 131);
        applyStimulus(980, 240, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555);
        #2 checkOutput("dut row1 right edge", 32'(pixel_addr), 0);
        nextRamp = 4'b0010;
        applyStimulus(64, 411, 1'b0, 1'b0, 1'b0, 1'b0, 12'h666);
        #2 checkOutput("dut ramp2 last line", 32'(pixel_addr), 1984);
        applyStimulus(3, 740, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC);
        applyStimulus(1100, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h111);
        applyStimulus(1100, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h222);
        #2 checkOutput("dut transparent keeps rgb", 32'(vout.rgb), 32'hABC);

        nextRst = 1'b1;
        repeat (3) randomActive();
        nextRst = 1'b0;
        runFrame();
        runFrame();
        nextStart = 1'b0;
        runFrame();

        @(posedge clk);
        #1 outValid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
